// File: rtl/mioc_flop_seq.sv
// Pattern sequencer/checker for the mioc_flop_nmos cell: drives in1..in4 from a small
// pattern memory, waits a settle time, samples q/qbar through a synchronizer and compares them.
//
// state    | meaning
// S_IDLE   | waiting for start; pattern memory writable
// S_LOAD   | register in1..in4 from mem[addr], arm settle counter
// S_SETTLE | count down until q/qbar have settled through the synchronizer
// S_SAMPLE | capture q/qbar, compare against expectation, advance
// S_DONE   | pulse done, publish pass, park cell inputs at 0
module mioc_flop_seq #(
  parameter int AW     = 4,
  parameter int SETTLE = 8,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [AW:0]      num_pat,
  input  logic             pat_we,
  input  logic [AW-1:0]    pat_addr,
  input  logic [6:0]       pat_wdata,
  output logic             in1,
  output logic             in2,
  output logic             in3,
  output logic             in4,
  input  logic             q,
  input  logic             qbar,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] err_count,
  output logic [AW-1:0]    first_err_addr,
  output logic             cap_valid,
  output logic [AW-1:0]    cap_addr,
  output logic             cap_q,
  output logic             cap_qbar
);

  localparam int          DEPTH     = 1 << AW;
  localparam logic [AW:0] MAX_PAT   = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_PAT   = (AW+1)'(1);
  localparam logic [7:0]  SETTLE_LD = 8'(SETTLE - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SETTLE,
    S_SAMPLE,
    S_DONE
  } state_t;

  state_t        state;
  logic [6:0]    mem [DEPTH];
  logic [6:0]    cur_pat;
  logic [AW-1:0] addr;
  logic [AW-1:0] last_addr;
  logic [7:0]    settle_cnt;
  logic          q_s1, q_s2, qbar_s1, qbar_s2;
  logic [AW:0]   num_clamped;
  logic          mismatch;

  assign num_clamped = (num_pat > MAX_PAT) ? MAX_PAT : num_pat;
  assign cur_pat     = mem[addr];
  assign mismatch    = cur_pat[0] && ({q_s2, qbar_s2} != cur_pat[2:1]);

  // Memory keeps its contents across reset so a run can be repeated after an abort.
  always_ff @(posedge clk) begin
    if (pat_we && state == S_IDLE) mem[pat_addr] <= pat_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_s1    <= 1'b0;
      q_s2    <= 1'b0;
      qbar_s1 <= 1'b0;
      qbar_s2 <= 1'b0;
    end else begin
      q_s1    <= q;
      q_s2    <= q_s1;
      qbar_s1 <= qbar;
      qbar_s2 <= qbar_s1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      addr           <= '0;
      last_addr      <= '0;
      settle_cnt     <= '0;
      {in1, in2, in3, in4} <= 4'b0000;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      err_count      <= '0;
      first_err_addr <= '0;
      cap_valid      <= 1'b0;
      cap_addr       <= '0;
      cap_q          <= 1'b0;
      cap_qbar       <= 1'b0;
    end else begin
      done      <= 1'b0;
      cap_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            last_addr      <= AW'(num_clamped - ONE_PAT);
            err_count      <= '0;
            first_err_addr <= '0;
            pass           <= 1'b0;
            addr           <= '0;
            busy           <= 1'b1;
            state          <= (num_clamped == '0) ? S_DONE : S_LOAD;
          end
        end
        S_LOAD: begin
          {in1, in2, in3, in4} <= cur_pat[6:3];
          settle_cnt <= SETTLE_LD;
          state      <= S_SETTLE;
        end
        S_SETTLE: begin
          if (settle_cnt == 8'd0) state <= S_SAMPLE;
          else settle_cnt <= settle_cnt - 8'd1;
        end
        S_SAMPLE: begin
          cap_valid <= 1'b1;
          cap_addr  <= addr;
          cap_q     <= q_s2;
          cap_qbar  <= qbar_s2;
          if (mismatch) begin
            if (err_count != '1) err_count <= err_count + CNT_W'(1);
            if (err_count == '0) first_err_addr <= addr;
          end
          if (addr == last_addr) begin
            state <= S_DONE;
          end else begin
            addr  <= addr + AW'(1);
            state <= S_LOAD;
          end
        end
        S_DONE: begin
          done  <= 1'b1;
          pass  <= (err_count == '0);
          busy  <= 1'b0;
          {in1, in2, in3, in4} <= 4'b0000;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
